// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_pkg
// Description : Shared constants for the I2C transaction sequencer: engine
//               op codes, sequencer state encoding, command-register bits.
// Revision    : 1.0  initial release
// ============================================================================
package i2c_pkg;

  // Byte-engine operation codes (eng_op)
  localparam logic [1:0] OP_START = 2'd0;
  localparam logic [1:0] OP_STOP  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;
  localparam logic [1:0] OP_READ  = 2'd3;

  // Sequencer state encoding
  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_ADDR      = 3'd2;
  localparam logic [2:0] S_WAIT_DATA = 3'd3;
  localparam logic [2:0] S_XFER      = 3'd4;
  localparam logic [2:0] S_STOP      = 3'd5;

  // Command-register bit positions in the APB register block
  localparam int CMD_EN_BIT = 0;
  localparam int CMD_GO_BIT = 1;
  localparam int CMD_RW_BIT = 2;

endpackage
`default_nettype wire

// File: rtl/i2c_txn_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : i2c_txn_sequencer_if
// Description : Command, FIFO, byte-engine and status signals of the I2C
//               transaction sequencer. master = sequencer side, slave = the
//               register block / FIFOs / byte engine side.
// Revision    : 1.0  initial release
// ============================================================================
interface i2c_txn_sequencer_if #(
  parameter int LEN_W = 8
) ();
  logic             enable;
  logic             cmd_go;
  logic             cmd_rw;
  logic [LEN_W-1:0] cmd_len;
  logic [6:0]       slave_addr;
  logic             tx_empty;
  logic [7:0]       tx_data;
  logic             tx_pop;
  logic             rx_full;
  logic             rx_push;
  logic [7:0]       rx_data;
  logic             eng_req;
  logic [1:0]       eng_op;
  logic [7:0]       eng_wdata;
  logic             eng_last;
  logic             eng_abort;
  logic             eng_done;
  logic             eng_ack;
  logic [7:0]       eng_rdata;
  logic             busy;
  logic             done;
  logic             nack_err;
  logic             to_err;

  modport master (
    input  enable, cmd_go, cmd_rw, cmd_len, slave_addr,
    input  tx_empty, tx_data, rx_full,
    input  eng_done, eng_ack, eng_rdata,
    output tx_pop, rx_push, rx_data,
    output eng_req, eng_op, eng_wdata, eng_last, eng_abort,
    output busy, done, nack_err, to_err
  );

  modport slave (
    output enable, cmd_go, cmd_rw, cmd_len, slave_addr,
    output tx_empty, tx_data, rx_full,
    output eng_done, eng_ack, eng_rdata,
    input  tx_pop, rx_push, rx_data,
    input  eng_req, eng_op, eng_wdata, eng_last, eng_abort,
    input  busy, done, nack_err, to_err
  );
endinterface
`default_nettype wire

// File: rtl/i2c_seq_timeout.sv
`default_nettype none
// ============================================================================
// Module      : i2c_seq_timeout
// Description : Engine-response watchdog. Counts while run is high, clears on
//               clr, expires on the (2^TO_W-1)-th consecutive run cycle.
// Revision    : 1.0  initial release
// ============================================================================
module i2c_seq_timeout #(
  parameter int TO_W = 16
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic i_clr,
  input  logic i_run,
  output logic o_expire
);
  localparam logic [TO_W-1:0] c_LIMIT = {{(TO_W-1){1'b1}}, 1'b0};
  localparam logic [TO_W-1:0] c_ONE   = {{(TO_W-1){1'b0}}, 1'b1};

  logic [TO_W-1:0] r_cnt;

  // Count request cycles; the count value at expiry is the (2^TO_W-1)-th cycle
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)                 r_cnt <= '0;
    else if (i_clr)               r_cnt <= '0;
    else if (i_run && !o_expire)  r_cnt <= r_cnt + c_ONE;
  end

  assign o_expire = i_run && (r_cnt == c_LIMIT);
endmodule
`default_nettype wire

// File: rtl/i2c_txn_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : i2c_txn_sequencer
// Description : Sequences START, address, N data bytes and STOP through the
//               byte engine, moving data between TX/RX FIFOs and the engine,
//               with engine-response timeout and enable-drop handling.
// Revision    : 1.0  initial release
// ============================================================================
module i2c_txn_sequencer
  import i2c_pkg::*;
#(
  parameter int LEN_W = 8,
  parameter int TO_W  = 16
) (
  input logic                 PCLK,
  input logic                 PRESETn,
  i2c_txn_sequencer_if.master bus
);
  localparam logic [LEN_W-1:0] c_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  logic [2:0]       r_state;
  logic [LEN_W-1:0] r_cnt;
  logic             r_rw;
  logic [6:0]       r_addr;
  logic             r_req;
  logic [1:0]       r_op;
  logic [7:0]       r_wdata;
  logic             r_last;
  logic             r_abort;
  logic             r_pop;
  logic             r_push;
  logic [7:0]       r_rdata;
  logic             r_busy;
  logic             r_done;
  logic             r_nack;
  logic             r_to;
  logic             w_expire;
  logic             w_hs_done;

  // A fresh request always follows a cycle with eng_req low, so clearing on
  // !r_req restarts the watchdog for every request.
  i2c_seq_timeout #(.TO_W(TO_W)) u_timeout (
    .PCLK     (PCLK),
    .PRESETn  (PRESETn),
    .i_clr    (!r_req),
    .i_run    (r_req),
    .o_expire (w_expire)
  );

  assign w_hs_done = r_req && bus.eng_done;

  // Transaction FSM, engine handshake and status flags
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rw    <= 1'b0;
      r_addr  <= '0;
      r_req   <= 1'b0;
      r_op    <= OP_START;
      r_wdata <= '0;
      r_last  <= 1'b0;
      r_abort <= 1'b0;
      r_pop   <= 1'b0;
      r_push  <= 1'b0;
      r_rdata <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_nack  <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      r_pop   <= 1'b0;
      r_push  <= 1'b0;
      r_done  <= 1'b0;
      r_abort <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.enable && bus.cmd_go) begin
            r_rw    <= bus.cmd_rw;
            r_addr  <= bus.slave_addr;
            r_cnt   <= bus.cmd_len;
            r_nack  <= 1'b0;
            r_to    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (!r_req) begin
            r_req <= 1'b1;
            r_op  <= OP_START;
          end else if (w_hs_done) begin
            r_req   <= 1'b0;
            r_state <= bus.enable ? S_ADDR : S_STOP;
          end
        end
        S_ADDR: begin
          if (!r_req) begin
            r_req   <= 1'b1;
            r_op    <= OP_WRITE;
            r_wdata <= {r_addr, r_rw};
            r_last  <= 1'b0;
          end else if (w_hs_done) begin
            r_req <= 1'b0;
            if (!bus.eng_ack) begin
              r_nack  <= 1'b1;
              r_state <= S_STOP;
            end else if (r_cnt == '0 || !bus.enable) begin
              r_state <= S_STOP;
            end else begin
              r_state <= S_WAIT_DATA;
            end
          end
        end
        S_WAIT_DATA: begin
          // Waits on the FIFOs are unbounded; only an enable drop leaves early
          if (!bus.enable) begin
            r_state <= S_STOP;
          end else if (!r_rw) begin
            if (!bus.tx_empty) begin
              r_pop   <= 1'b1;
              r_wdata <= bus.tx_data;
              r_state <= S_XFER;
            end
          end else if (!bus.rx_full) begin
            r_state <= S_XFER;
          end
        end
        S_XFER: begin
          if (!r_req) begin
            r_req  <= 1'b1;
            r_op   <= r_rw ? OP_READ : OP_WRITE;
            r_last <= r_rw && (r_cnt == c_ONE);
          end else if (w_hs_done) begin
            r_req <= 1'b0;
            if (r_cnt != '0) r_cnt <= r_cnt - c_ONE;
            if (r_rw) begin
              r_push  <= 1'b1;
              r_rdata <= bus.eng_rdata;
            end
            if (!r_rw && !bus.eng_ack) begin
              r_nack  <= 1'b1;
              r_state <= S_STOP;
            end else if (r_cnt <= c_ONE || !bus.enable) begin
              r_state <= S_STOP;
            end else begin
              r_state <= S_WAIT_DATA;
            end
          end
        end
        S_STOP: begin
          if (!r_req) begin
            r_req  <= 1'b1;
            r_op   <= OP_STOP;
            r_last <= 1'b0;
          end else if (w_hs_done) begin
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // A stuck engine overrides whatever the state wanted this cycle:
      // abort it and return to IDLE without issuing STOP.
      if (r_req && !bus.eng_done && w_expire) begin
        r_req   <= 1'b0;
        r_abort <= 1'b1;
        r_to    <= 1'b1;
        r_done  <= 1'b1;
        r_busy  <= 1'b0;
        r_state <= S_IDLE;
      end
    end
  end

  assign bus.eng_req   = r_req;
  assign bus.eng_op    = r_op;
  assign bus.eng_wdata = r_wdata;
  assign bus.eng_last  = r_last;
  assign bus.eng_abort = r_abort;
  assign bus.tx_pop    = r_pop;
  assign bus.rx_push   = r_push;
  assign bus.rx_data   = r_rdata;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.nack_err  = r_nack;
  assign bus.to_err    = r_to;
endmodule
`default_nettype wire

// File: tb/tb_i2c_txn_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_txn_sequencer
// Description : Directed self-checking bench for i2c_txn_sequencer with a
//               behavioural byte engine and TX FIFO, TO_W=4.
// Revision    : 1.0  initial release
// ============================================================================
module tb_i2c_txn_sequencer;
  import i2c_pkg::*;

  localparam int LAT = 3;

  logic PCLK = 1'b0;
  logic PRESETn;
  i2c_txn_sequencer_if #(.LEN_W(8)) bus ();

  i2c_txn_sequencer #(.LEN_W(8), .TO_W(4)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .bus     (bus)
  );

  always #5 PCLK = ~PCLK;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0] op_log[$];
  logic [7:0] wd_log[$];
  logic       last_log[$];
  logic [7:0] rx_log[$];
  logic [7:0] tx_q[$];
  logic [7:0] rd_q[$];
  int  pop_cnt, done_cnt, abort_cnt, rd_ops, req_len, last_req_len, wcnt;
  logic prev_req, busy_at_done, abort_at_done, hang, nack_mode, force_empty;

  // Negedge model: op monitor, TX FIFO, and a byte engine answering after LAT
  always @(negedge PCLK) begin
    if (bus.eng_req && !prev_req) begin
      op_log.push_back(bus.eng_op);
      wd_log.push_back(bus.eng_wdata);
      last_log.push_back(bus.eng_last);
      if (bus.eng_op == OP_READ) rd_ops++;
      req_len = 0;
    end
    if (bus.eng_req) req_len++;
    if (!bus.eng_req && prev_req) last_req_len = req_len;
    prev_req = bus.eng_req;
    if (bus.tx_pop) begin
      pop_cnt++;
      if (tx_q.size() > 0) void'(tx_q.pop_front());
    end
    if (bus.rx_push) rx_log.push_back(bus.rx_data);
    if (bus.eng_abort) abort_cnt++;
    if (bus.done) begin
      done_cnt++;
      busy_at_done  = bus.busy;
      abort_at_done = bus.eng_abort;
    end
    bus.tx_empty = force_empty || (tx_q.size() == 0);
    bus.tx_data  = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
    if (!PRESETn || bus.eng_done) begin
      bus.eng_done = 1'b0;
      wcnt = 0;
    end else if (bus.eng_req && !hang) begin
      if (wcnt == LAT) begin
        bus.eng_done = 1'b1;
        bus.eng_ack  = !nack_mode;
        if (bus.eng_op == OP_READ)
          bus.eng_rdata = (rd_q.size() > 0) ? rd_q.pop_front() : 8'hEE;
      end else begin
        wcnt++;
      end
    end else if (!bus.eng_req) begin
      wcnt = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_op(input string tag, input int idx, input logic [1:0] op, input logic [7:0] wd);
    chk({tag, " op"}, {30'd0, op_log[idx]}, {30'd0, op});
    if (op == OP_WRITE) chk({tag, " wdata"}, {24'd0, wd_log[idx]}, {24'd0, wd});
  endtask

  task automatic clear_logs();
    op_log.delete(); wd_log.delete(); last_log.delete(); rx_log.delete();
    pop_cnt = 0; done_cnt = 0; abort_cnt = 0; rd_ops = 0;
  endtask

  task automatic go(input logic rw, input logic [7:0] len, input logic [6:0] addr);
    @(negedge PCLK);
    bus.cmd_rw = rw; bus.cmd_len = len; bus.slave_addr = addr; bus.cmd_go = 1'b1;
    @(negedge PCLK);
    bus.cmd_go = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int start;
    start = done_cnt;
    for (int i = 0; i < budget && done_cnt == start; i++) @(negedge PCLK);
    chk({tag, " done seen in budget"}, {31'd0, done_cnt != start}, 32'd1);
    repeat (3) @(negedge PCLK);
  endtask

  initial begin
    bus.enable = 1'b0; bus.cmd_go = 1'b0; bus.cmd_rw = 1'b0; bus.cmd_len = '0;
    bus.slave_addr = '0; bus.tx_empty = 1'b1; bus.tx_data = '0; bus.rx_full = 1'b0;
    bus.eng_done = 1'b0; bus.eng_ack = 1'b0; bus.eng_rdata = '0;
    hang = 1'b0; nack_mode = 1'b0; force_empty = 1'b0; prev_req = 1'b0;
    req_len = 0; last_req_len = 0; wcnt = 0; busy_at_done = 1'b0; abort_at_done = 1'b0;
    clear_logs();
    PRESETn = 1'b1;
    #2 PRESETn = 1'b0;
    repeat (3) @(negedge PCLK);

    // Reset state
    chk("rst busy", {31'd0, bus.busy}, 32'd0);
    chk("rst done", {31'd0, bus.done}, 32'd0);
    chk("rst eng_req", {31'd0, bus.eng_req}, 32'd0);
    chk("rst eng_op", {30'd0, bus.eng_op}, 32'd0);
    chk("rst nack/to", {30'd0, bus.nack_err, bus.to_err}, 32'd0);
    chk("rst strobes", {29'd0, bus.tx_pop, bus.rx_push, bus.eng_abort}, 32'd0);
    PRESETn = 1'b1;
    repeat (2) @(negedge PCLK);

    // cmd_go with enable=0 is ignored
    go(1'b0, 8'd2, 7'h50);
    repeat (8) @(negedge PCLK);
    chk("disabled go busy", {31'd0, bus.busy}, 32'd0);
    chk("disabled go ops", op_log.size(), 32'd0);
    bus.enable = 1'b1;

    // Write len=2 to 0x50
    clear_logs();
    tx_q = '{8'hA5, 8'h3C};
    go(1'b0, 8'd2, 7'h50);
    repeat (2) @(negedge PCLK);
    chk("wr busy", {31'd0, bus.busy}, 32'd1);
    wait_done("wr", 200);
    chk("wr nops", op_log.size(), 32'd5);
    chk_op("wr0", 0, OP_START, 8'h00);
    chk_op("wr1", 1, OP_WRITE, 8'hA0);
    chk_op("wr2", 2, OP_WRITE, 8'hA5);
    chk_op("wr3", 3, OP_WRITE, 8'h3C);
    chk_op("wr4", 4, OP_STOP, 8'h00);
    chk("wr pops", pop_cnt, 32'd2);
    chk("wr dones", done_cnt, 32'd1);
    chk("wr nack", {31'd0, bus.nack_err}, 32'd0);
    chk("wr busy end", {31'd0, bus.busy}, 32'd0);

    // Read len=3 from 0x21
    clear_logs();
    rd_q = '{8'h11, 8'h22, 8'h33};
    go(1'b1, 8'd3, 7'h21);
    wait_done("rd", 300);
    chk("rd nops", op_log.size(), 32'd6);
    chk_op("rd1", 1, OP_WRITE, 8'h43);
    chk_op("rd2", 2, OP_READ, 8'h00);
    chk_op("rd4", 4, OP_READ, 8'h00);
    chk_op("rd5", 5, OP_STOP, 8'h00);
    chk("rd last", {29'd0, last_log[2], last_log[3], last_log[4]}, 32'b001);
    chk("rd pushes", rx_log.size(), 32'd3);
    chk("rd data", {8'd0, rx_log[0], rx_log[1], rx_log[2]}, 32'h00112233);
    chk("rd dones", done_cnt, 32'd1);

    // Address NACK, write len=4
    clear_logs();
    nack_mode = 1'b1;
    tx_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    go(1'b0, 8'd4, 7'h2A);
    wait_done("nack", 200);
    nack_mode = 1'b0;
    chk("nack nops", op_log.size(), 32'd3);
    chk_op("nack1", 1, OP_WRITE, 8'h54);
    chk_op("nack2", 2, OP_STOP, 8'h00);
    chk("nack pops", pop_cnt, 32'd0);
    chk("nack flag", {31'd0, bus.nack_err}, 32'd1);
    chk("nack dones", done_cnt, 32'd1);
    tx_q.delete();
    repeat (2) @(negedge PCLK);

    // Write len=3 with TX FIFO empty for 50 cycles before byte 2
    clear_logs();
    tx_q = '{8'h01};
    go(1'b0, 8'd3, 7'h10);
    chk("stall nack cleared", {31'd0, bus.nack_err}, 32'd0);
    for (int i = 0; i < 100 && pop_cnt < 1; i++) @(negedge PCLK);
    repeat (50) @(negedge PCLK);
    chk("stall req low", {31'd0, bus.eng_req}, 32'd0);
    chk("stall busy", {31'd0, bus.busy}, 32'd1);
    chk("stall to_err", {31'd0, bus.to_err}, 32'd0);
    chk("stall nops", op_log.size(), 32'd3);
    tx_q.push_back(8'h02);
    tx_q.push_back(8'h03);
    wait_done("stall", 300);
    chk("stall total ops", op_log.size(), 32'd6);
    chk_op("stall3", 3, OP_WRITE, 8'h02);
    chk_op("stall4", 4, OP_WRITE, 8'h03);
    chk("stall pops", pop_cnt, 32'd3);
    chk("stall to_err end", {31'd0, bus.to_err}, 32'd0);

    // Engine never answers START (TO_W=4)
    clear_logs();
    hang = 1'b1;
    go(1'b0, 8'd1, 7'h10);
    wait_done("to", 200);
    chk("to req cycles", last_req_len, 32'd15);
    chk("to flag", {31'd0, bus.to_err}, 32'd1);
    chk("to abort", abort_cnt, 32'd1);
    chk("to abort with done", {31'd0, abort_at_done}, 32'd1);
    chk("to busy at done", {31'd0, busy_at_done}, 32'd0);
    chk("to no STOP", op_log.size(), 32'd1);
    hang = 1'b0;

    // Address-only probe clears to_err
    clear_logs();
    go(1'b0, 8'd0, 7'h10);
    chk("probe to cleared", {31'd0, bus.to_err}, 32'd0);
    wait_done("probe", 200);
    chk("probe nops", op_log.size(), 32'd3);
    chk_op("probe1", 1, OP_WRITE, 8'h20);
    chk_op("probe2", 2, OP_STOP, 8'h00);

    // Read len=5; second cmd_go while busy; enable drops during byte 2
    clear_logs();
    rd_q = '{8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
    go(1'b1, 8'd5, 7'h33);
    repeat (2) @(negedge PCLK);
    go(1'b0, 8'd1, 7'h7F);
    for (int i = 0; i < 200 && rd_ops < 2; i++) @(negedge PCLK);
    bus.enable = 1'b0;
    wait_done("endrop", 200);
    bus.enable = 1'b1;
    chk("endrop nops", op_log.size(), 32'd5);
    chk_op("endrop1", 1, OP_WRITE, 8'h67);
    chk_op("endrop3", 3, OP_READ, 8'h00);
    chk_op("endrop4", 4, OP_STOP, 8'h00);
    chk("endrop last", {30'd0, last_log[2], last_log[3]}, 32'd0);
    chk("endrop pushes", rx_log.size(), 32'd2);
    chk("endrop data", {16'd0, rx_log[0], rx_log[1]}, 32'h00005566);
    chk("endrop dones", done_cnt, 32'd1);
    chk("endrop flags", {30'd0, bus.nack_err, bus.to_err}, 32'd0);

    // Asynchronous reset mid-transaction
    clear_logs();
    tx_q = '{8'hC3};
    go(1'b0, 8'd1, 7'h40);
    for (int i = 0; i < 100 && op_log.size() < 2; i++) @(negedge PCLK);
    chk("arst in flight", {31'd0, bus.eng_req}, 32'd1);
    #1 PRESETn = 1'b0;
    #1;
    chk("arst eng_req", {31'd0, bus.eng_req}, 32'd0);
    chk("arst busy", {31'd0, bus.busy}, 32'd0);
    chk("arst wdata", {24'd0, bus.eng_wdata}, 32'd0);
    repeat (5) @(negedge PCLK);
    chk("arst no STOP", op_log.size(), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
